// File: rtl/btn_if.sv
// Push-button bundle between the raw pad lines and the conditioner.
// rpt_state carries each button's repeat-FSM state (2 bits per button) for observation.
interface btn_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0]   btn_raw;
  logic [N_BTN-1:0]   btn_level;
  logic [N_BTN-1:0]   btn_press;
  logic [N_BTN-1:0]   btn_move;
  logic [2*N_BTN-1:0] rpt_state;

  // No handshake: btn_raw is a free-running level; every output is a registered
  // level or single-cycle pulse with no backpressure.
  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_move,
    input  rpt_state
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_move,
    output rpt_state
  );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop sync, debounce, press pulse and typematic move pulses.
// Optional auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 20_000_000,
  parameter int REPEAT_PERIOD   = 524_288
) (
  input  logic pixclk,
  input  logic rst,
  btn_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] D_TERM = DW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [DW-1:0]    cnt [N_BTN];

  always_ff @(posedge pixclk) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.btn_raw;
      s2 <= s1;
    end
  end

  // A commit happens when the disagreement has lasted DEBOUNCE_CYCLES edges.
  always_comb begin
    rise = '0;
    fall = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if ((s2[i] != level[i]) && (cnt[i] == D_TERM)) begin
        rise[i] = s2[i];
        fall[i] = ~s2[i];
      end
    end
  end

  always_ff @(posedge pixclk) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (s2[i] == level[i])     cnt[i] <= '0;
        else if (cnt[i] == D_TERM) cnt[i] <= '0;
        else                       cnt[i] <= cnt[i] + DW'(1);
      end
    end
  end

  always_ff @(posedge pixclk) begin
    if (!rst) begin
      level <= '0;
      press <= '0;
    end else begin
      level <= (level | rise) & ~fall;
      press <= rise;
    end
  end

  assign bus.btn_level = level;
  assign bus.btn_press = press;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_TERM = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_TERM = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  rpt_state_t       state_q [N_BTN];
  rpt_state_t       state_d [N_BTN];
  logic [RW-1:0]    rcnt_q  [N_BTN];
  logic [RW-1:0]    rcnt_d  [N_BTN];
  logic [N_BTN-1:0] move_d;
  logic [N_BTN-1:0] move_q;
  logic [2*N_BTN-1:0] state_flat;

  always_ff @(posedge pixclk) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        rcnt_q[i]  <= '0;
      end
      move_q <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
      move_q <= move_d;
    end
  end

  // A debounced release wins over any terminal count landing on the same edge.
  always_comb begin
    move_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];
      if (fall[i]) begin
        state_d[i] = IDLE;
        rcnt_d[i]  = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (rise[i]) begin
              move_d[i]  = 1'b1;
              state_d[i] = DELAY;
              rcnt_d[i]  = '0;
            end
          end
          DELAY: begin
            if (rcnt_q[i] == RD_TERM) begin
              move_d[i]  = 1'b1;
              state_d[i] = REPEAT;
              rcnt_d[i]  = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end
          REPEAT: begin
            if (rcnt_q[i] == RP_TERM) begin
              move_d[i] = 1'b1;
              rcnt_d[i] = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end
          default: begin
            state_d[i] = IDLE;
            rcnt_d[i]  = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    state_flat = '0;
    for (int i = 0; i < N_BTN; i++) state_flat[2*i +: 2] = state_q[i];
  end

  assign bus.btn_move  = move_q;
  assign bus.rpt_state = state_flat;
`else
  assign bus.btn_move  = press;
  assign bus.rpt_state = '0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
// Expectations follow BTN_AUTOREPEAT_EN so the same file covers both builds.
module tb_btn_conditioner;

  localparam int N = 4;

  logic pixclk = 1'b0;
  logic rst    = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  btn_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .pixclk(pixclk),
    .rst(rst),
    .bus(bus)
  );

  always #5 pixclk = ~pixclk;

  task automatic step();
    @(posedge pixclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                          input logic [3:0] mov);
    chk({tag, "_level"}, {4'h0, bus.btn_level}, {4'h0, lvl});
    chk({tag, "_press"}, {4'h0, bus.btn_press}, {4'h0, prs});
    chk({tag, "_move"},  {4'h0, bus.btn_move},  {4'h0, mov});
  endtask

  logic [3:0] exp_mv;
  logic [1:0] exp_st;

  initial begin
    bus.btn_raw = 4'hF;

    // Reset held with all buttons pressed
    repeat (3) begin
      step();
      chk_outs("reset", 4'h0, 4'h0, 4'h0);
    end
    chk("reset_state", bus.rpt_state, 8'h00);
    rst = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 6) chk_outs("rel_press", 4'hF, 4'hF, 4'hF);
      else        chk_outs("rel_wait",  4'h0, 4'h0, 4'h0);
    end
    step();
    chk_outs("rel_after", 4'hF, 4'h0, 4'h0);
    bus.btn_raw = 4'h0;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk({4'h0, bus.btn_press}, 8'h00 == 8'h00 ? {4'h0, bus.btn_press} : 8'h00, 8'h00);
    end
    chk_outs("all_released", 4'h0, 4'h0, 4'h0);
    chk("released_state", bus.rpt_state, 8'h00);

    // Bounce: 3-cycle burst, 1-cycle gap, then steady
    bus.btn_raw = 4'h1;
    repeat (3) begin
      step();
      chk_outs("burst", 4'h0, 4'h0, 4'h0);
    end
    bus.btn_raw = 4'h0;
    step();
    chk_outs("gap", 4'h0, 4'h0, 4'h0);
    bus.btn_raw = 4'h1;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 6) chk_outs("bounce_press", 4'h1, 4'h1, 4'h1);
      else        chk_outs("bounce_wait",  4'h0, 4'h0, 4'h0);
    end
    bus.btn_raw = 4'h0;
    repeat (12) step();
    chk_outs("bounce_release", 4'h0, 4'h0, 4'h0);

    // Hold button 1, release so the debounced fall meets a repeat terminal count
    bus.btn_raw = 4'h2;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 6) chk_outs("hold_press", 4'h2, 4'h2, 4'h2);
      else        chk_outs("hold_wait",  4'h0, 4'h0, 4'h0);
    end
    for (int k = 1; k <= 40; k++) begin
      step();
`ifdef BTN_AUTOREPEAT_EN
      exp_mv = (k >= 10 && k < 40 && ((k - 10) % 3) == 0) ? 4'h2 : 4'h0;
      exp_st = (k >= 40) ? 2'd0 : (k >= 10) ? 2'd2 : 2'd1;
`else
      exp_mv = 4'h0;
      exp_st = 2'd0;
`endif
      chk_outs("hold", (k < 40) ? 4'h2 : 4'h0, 4'h0, exp_mv);
      if (k == 5 || k == 20 || k == 40)
        chk("hold_state", {6'h0, bus.rpt_state[3:2]}, {6'h0, exp_st});
      if (k == 34) bus.btn_raw = 4'h0;
    end
    repeat (3) begin
      step();
      chk_outs("post_release", 4'h0, 4'h0, 4'h0);
    end

    // Simultaneous presses on buttons 2 and 3
    bus.btn_raw = 4'hC;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 6) chk_outs("simul_press", 4'hC, 4'hC, 4'hC);
      else        chk_outs("simul_wait",  4'h0, 4'h0, 4'h0);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
`ifdef BTN_AUTOREPEAT_EN
      exp_mv = (k == 10) ? 4'hC : 4'h0;
`else
      exp_mv = 4'h0;
`endif
      chk_outs("simul_hold", 4'hC, 4'h0, exp_mv);
    end

    // Reset mid-hold, then a fresh press after release
    rst = 1'b0;
    step();
    chk_outs("midrst", 4'h0, 4'h0, 4'h0);
    chk("midrst_state", bus.rpt_state, 8'h00);
    rst = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 6) chk_outs("refresh_press", 4'hC, 4'hC, 4'hC);
      else        chk_outs("refresh_wait",  4'h0, 4'h0, 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
